// File: rtl/calc_entry.sv
// Keypad-to-number entry engine: turns decoded button levels into a num_t operand
// digit by digit and commits it to the arithmetic unit on an operator or equals press.
package calc_pkg;
  localparam int NumDigits = 8;

  typedef logic [3:0] digit_t;

  typedef struct packed {
    logic                        sign;
    logic                        error;
    logic [3:0]                  exponent;
    digit_t [NumDigits-1:0]      significand;
  } num_t;

  typedef enum logic [4:0] {
    B_NONE       = 5'd0,
    B_NUM_0      = 5'd1,
    B_NUM_1, B_NUM_2, B_NUM_3, B_NUM_4, B_NUM_5,
    B_NUM_6, B_NUM_7, B_NUM_8, B_NUM_9,
    B_DOT        = 5'd11,
    B_OP_ADD     = 5'd12,
    B_OP_SUB, B_OP_MUL, B_OP_DIV, B_OP_EQ,
    B_OP_PERCENT = 5'd17,
    B_OP_SQRT, B_MEM_PLUS, B_MEM_MINUS, B_MEM_RECALL, B_MEM_CLEAR,
    B_CLEAR      = 5'd23,
    B_UNKNOWN    = 5'd31
  } active_button_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD, OP_SUB, OP_MUL, OP_DIV
  } op_t;

  function automatic op_t button2op(active_button_t b);
    op_t op;
    op = OP_NONE;
    case (b)
      B_OP_ADD: op = OP_ADD;
      B_OP_SUB: op = OP_SUB;
      B_OP_MUL: op = OP_MUL;
      B_OP_DIV: op = OP_DIV;
      default:  op = OP_NONE;
    endcase
    return op;
  endfunction

  function automatic digit_t button2digit(active_button_t b);
    digit_t d;
    d = '0;
    case (b)
      B_NUM_1: d = 4'd1;
      B_NUM_2: d = 4'd2;
      B_NUM_3: d = 4'd3;
      B_NUM_4: d = 4'd4;
      B_NUM_5: d = 4'd5;
      B_NUM_6: d = 4'd6;
      B_NUM_7: d = 4'd7;
      B_NUM_8: d = 4'd8;
      B_NUM_9: d = 4'd9;
      default: d = 4'd0;
    endcase
    return d;
  endfunction
endpackage

module calc_entry
  import calc_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  active_button_t active_button_i,
  input  logic           load_i,
  input  num_t           load_num_i,
  output num_t           num_o,
  output logic           entering_o,
  output logic           commit_o,
  output op_t            commit_op_o
);
  typedef enum logic [1:0] {S_FRESH, S_INT, S_FRAC} state_t;

  state_t         r_state;
  logic [3:0]     r_count;
  active_button_t r_prevBtn;
  num_t           r_num;
  logic           r_commit;
  op_t            r_commitOp;

  logic           w_press;
  logic           w_isDigit;
  logic           w_isDot;
  logic           w_isOp;
  logic           w_isClear;
  logic           w_canWrite;
  digit_t         w_digit;
  logic [2:0]     w_slot;

  // A key only counts on its transition out of B_NONE; B_UNKNOWN never counts.
  assign w_press    = (r_prevBtn == B_NONE) && (active_button_i != B_NONE) &&
                      (active_button_i != B_UNKNOWN);
  assign w_isDigit  = active_button_i inside {[B_NUM_0:B_NUM_9]};
  assign w_isDot    = (active_button_i == B_DOT);
  assign w_isOp     = active_button_i inside {B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV, B_OP_EQ};
  assign w_isClear  = (active_button_i == B_CLEAR);
  assign w_digit    = button2digit(active_button_i);
  assign w_slot     = 3'(4'(NumDigits - 1) - r_count);
  assign w_canWrite = (r_count < 4'(NumDigits));

  assign num_o       = r_num;
  assign entering_o  = (r_state != S_FRESH);
  assign commit_o    = r_commit;
  assign commit_op_o = r_commitOp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_FRESH;
      r_count    <= '0;
      r_prevBtn  <= B_NONE;
      r_num      <= '0;
      r_commit   <= 1'b0;
      r_commitOp <= OP_NONE;
    end else begin
      r_prevBtn  <= active_button_i;
      r_commit   <= 1'b0;
      r_commitOp <= OP_NONE;
      if (w_press && w_isClear) begin
        r_num   <= '0;
        r_state <= S_FRESH;
        r_count <= '0;
      end else if (load_i) begin
        r_num   <= load_num_i;
        r_state <= S_FRESH;
        r_count <= '0;
      end else if (w_press && w_isOp) begin
        r_commit   <= 1'b1;
        r_commitOp <= button2op(active_button_i);
        r_state    <= S_FRESH;
        r_count    <= '0;
      end else if (w_press && w_isDot) begin
        if (r_state == S_FRESH) begin
          r_num   <= '0;
          r_count <= '0;
          r_state <= S_FRAC;
        end else if (r_state == S_INT) begin
          r_state <= S_FRAC;
        end
      end else if (w_press && w_isDigit) begin
        case (r_state)
          S_FRESH: begin
            r_num                          <= '0;
            r_num.significand[NumDigits-1] <= w_digit;
            r_count                        <= (w_digit != 4'd0) ? 4'd1 : 4'd0;
            r_state                        <= S_INT;
          end
          S_INT: begin
            if (w_canWrite && !(r_count == 4'd0 && w_digit == 4'd0)) begin
              r_num.significand[w_slot] <= w_digit;
              if (r_count != 4'd0) r_num.exponent <= r_count;
              r_count <= r_count + 4'd1;
            end
          end
          S_FRAC: begin
            // A first significant digit after the point means magnitude < 1.
            if (!r_num.error && w_canWrite) begin
              if (r_count == 4'd0) begin
                if (w_digit != 4'd0) r_num.error <= 1'b1;
              end else begin
                r_num.significand[w_slot] <= w_digit;
                r_count <= r_count + 4'd1;
              end
            end
          end
          default: r_state <= S_FRESH;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_calc_entry.sv
// Self-checking bench for calc_entry: table vectors, hand-written reset/unknown-key
// sequences and randomized key traffic compared against a digit-queue reference model.
module tb_calc_entry;
  import calc_pkg::*;

  logic           clk = 1'b0;
  logic           rstN = 1'b1;
  active_button_t btn = B_NONE;
  logic           load = 1'b0;
  num_t           loadNum = '0;
  num_t           numOut;
  logic           entering;
  logic           commit;
  op_t            commitOp;

  int checks = 0;
  int fails  = 0;

  calc_entry dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .active_button_i(btn),
    .load_i         (load),
    .load_num_i     (loadNum),
    .num_o          (numOut),
    .entering_o     (entering),
    .commit_o       (commit),
    .commit_op_o    (commitOp)
  );

  always #5 clk = ~clk;

  // Reference model: the operand is the list of significant digits typed so far,
  // plus how many of them precede the decimal point.
  active_button_t mPrev;
  num_t           mNum;
  bit             mEnt;
  bit             mCommit;
  op_t            mOp;
  int             mDigs[$];
  int             mIntCnt;
  bit             mFrac;
  bit             mErr;

  function automatic num_t mkNum(bit err, int exp, logic [31:0] sig);
    num_t n;
    n = '0;
    n.error       = err;
    n.exponent    = 4'(exp);
    n.significand = sig;
    return n;
  endfunction

  function automatic void modelReset();
    mPrev   = B_NONE;
    mNum    = '0;
    mEnt    = 1'b0;
    mCommit = 1'b0;
    mOp     = OP_NONE;
    mDigs.delete();
    mIntCnt = 0;
    mFrac   = 1'b0;
    mErr    = 1'b0;
  endfunction

  function automatic void modelStartEntry();
    if (!mEnt) begin
      mDigs.delete();
      mIntCnt = 0;
      mFrac   = 1'b0;
      mErr    = 1'b0;
      mEnt    = 1'b1;
    end
  endfunction

  function automatic void modelBuild();
    num_t n;
    n = '0;
    for (int i = 0; i < mDigs.size(); i++) n.significand[7-i] = 4'(mDigs[i]);
    n.exponent = 4'((mIntCnt > 0) ? mIntCnt - 1 : 0);
    n.error    = mErr;
    mNum = n;
  endfunction

  function automatic void modelStep(active_button_t b, bit ld, num_t ldv);
    bit press;
    int d;
    press   = (mPrev == B_NONE) && (b != B_NONE) && (b != B_UNKNOWN);
    mPrev   = b;
    mCommit = 1'b0;
    mOp     = OP_NONE;
    if (press && b == B_CLEAR) begin
      mNum = '0;
      mEnt = 1'b0;
    end else if (ld) begin
      mNum = ldv;
      mEnt = 1'b0;
    end else if (press) begin
      case (b)
        B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV, B_OP_EQ: begin
          mCommit = 1'b1;
          mOp = (b == B_OP_ADD) ? OP_ADD : (b == B_OP_SUB) ? OP_SUB :
                (b == B_OP_MUL) ? OP_MUL : (b == B_OP_DIV) ? OP_DIV : OP_NONE;
          mEnt = 1'b0;
        end
        B_DOT: begin
          modelStartEntry();
          mFrac = 1'b1;
          modelBuild();
        end
        default: begin
          if (b >= B_NUM_0 && b <= B_NUM_9) begin
            d = int'(b) - int'(B_NUM_0);
            modelStartEntry();
            if (mErr || mDigs.size() >= 8) begin
            end else if (mDigs.size() == 0 && d == 0) begin
            end else if (mDigs.size() == 0 && mFrac) begin
              mErr = 1'b1;
            end else begin
              mDigs.push_back(d);
              if (!mFrac) mIntCnt++;
            end
            modelBuild();
          end
        end
      endcase
    end
  endfunction

  task automatic applyStimulus(active_button_t b, bit ld, num_t ldv);
    btn     = b;
    load    = ld;
    loadNum = ldv;
    if (rstN) modelStep(b, ld, ldv);
    else      modelReset();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, num_t eNum, bit eEnt, bit eCom, op_t eOp);
    checks++;
    if (numOut !== eNum) begin
      fails++;
      $display("[TB] FAIL %s num_o: got %h want %h", name, numOut, eNum);
    end
    checks++;
    if (entering !== eEnt) begin
      fails++;
      $display("[TB] FAIL %s entering_o: got %b want %b", name, entering, eEnt);
    end
    checks++;
    if (commit !== eCom) begin
      fails++;
      $display("[TB] FAIL %s commit_o: got %b want %b", name, commit, eCom);
    end
    checks++;
    if (commitOp !== eOp) begin
      fails++;
      $display("[TB] FAIL %s commit_op_o: got %0d want %0d", name, commitOp, eOp);
    end
  endtask

  typedef struct {
    active_button_t btn;
    int             hold;
    bit             ld;
    num_t           ldVal;
    num_t           eNum;
    bit             eEnt;
    bit             eCom;
    op_t            eOp;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(active_button_t b, int hold, bit ld, num_t ldv,
                                 num_t eNum, bit eEnt, bit eCom, op_t eOp);
    vec_t v;
    v.btn = b; v.hold = hold; v.ld = ld; v.ldVal = ldv;
    v.eNum = eNum; v.eEnt = eEnt; v.eCom = eCom; v.eOp = eOp;
    vecs.push_back(v);
  endfunction

  function automatic active_button_t randBtn();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55)      return active_button_t'(5'(int'(B_NUM_0) + $urandom_range(0, 9)));
    else if (r < 63) return B_DOT;
    else if (r < 73) return active_button_t'(5'(int'(B_OP_ADD) + $urandom_range(0, 4)));
    else if (r < 76) return B_CLEAR;
    else if (r < 81) return B_UNKNOWN;
    else if (r < 87) return active_button_t'(5'(int'(B_OP_PERCENT) + $urandom_range(0, 5)));
    else             return B_NONE;
  endfunction

  initial begin
    num_t zero;
    num_t fortyTwo;
    logic [63:0] rnd;
    active_button_t rb;
    bit rl;
    num_t rv;

    zero     = '0;
    fortyTwo = mkNum(0, 1, 32'h4200_0000);

    // Basic integer entry held 3 cycles, then commit with ADD.
    addVec(B_NUM_1, 3, 0, zero, mkNum(0, 0, 32'h1000_0000), 1, 0, OP_NONE);
    addVec(B_NUM_2, 3, 0, zero, mkNum(0, 1, 32'h1200_0000), 1, 0, OP_NONE);
    addVec(B_NUM_3, 3, 0, zero, mkNum(0, 2, 32'h1230_0000), 1, 0, OP_NONE);
    addVec(B_OP_ADD, 3, 0, zero, mkNum(0, 2, 32'h1230_0000), 0, 1, OP_ADD);
    // Leading zeros, fraction digits, second dot.
    addVec(B_NUM_0, 1, 0, zero, zero, 1, 0, OP_NONE);
    addVec(B_NUM_0, 1, 0, zero, zero, 1, 0, OP_NONE);
    addVec(B_NUM_1, 1, 0, zero, mkNum(0, 0, 32'h1000_0000), 1, 0, OP_NONE);
    addVec(B_NUM_2, 1, 0, zero, mkNum(0, 1, 32'h1200_0000), 1, 0, OP_NONE);
    addVec(B_DOT,   1, 0, zero, mkNum(0, 1, 32'h1200_0000), 1, 0, OP_NONE);
    addVec(B_NUM_5, 1, 0, zero, mkNum(0, 1, 32'h1250_0000), 1, 0, OP_NONE);
    addVec(B_DOT,   1, 0, zero, mkNum(0, 1, 32'h1250_0000), 1, 0, OP_NONE);
    addVec(B_NUM_7, 1, 0, zero, mkNum(0, 1, 32'h1257_0000), 1, 0, OP_NONE);
    addVec(B_OP_EQ, 1, 0, zero, mkNum(0, 1, 32'h1257_0000), 0, 1, OP_NONE);
    // Pure fraction is unrepresentable.
    addVec(B_DOT,   2, 0, zero, zero, 1, 0, OP_NONE);
    addVec(B_NUM_0, 1, 0, zero, zero, 1, 0, OP_NONE);
    addVec(B_NUM_5, 1, 0, zero, mkNum(1, 0, 32'h0), 1, 0, OP_NONE);
    addVec(B_NUM_3, 1, 0, zero, mkNum(1, 0, 32'h0), 1, 0, OP_NONE);
    addVec(B_OP_EQ, 1, 0, zero, mkNum(1, 0, 32'h0), 0, 1, OP_NONE);
    // Nine nines: the ninth is dropped.
    for (int k = 1; k <= 9; k++) begin
      int kk;
      kk = (k > 8) ? 8 : k;
      addVec(B_NUM_9, 2, 0, zero, mkNum(0, kk - 1, 32'hFFFF_FFFF & (32'h9999_9999 << (4 * (8 - kk)))),
             1, 0, OP_NONE);
    end
    addVec(B_CLEAR, 1, 0, zero, zero, 0, 0, OP_NONE);
    // Load beats a digit press, clear beats load, load beats an operator.
    addVec(B_NUM_7, 1, 1, fortyTwo, fortyTwo, 0, 0, OP_NONE);
    addVec(B_NUM_7, 1, 0, zero, mkNum(0, 0, 32'h7000_0000), 1, 0, OP_NONE);
    addVec(B_OP_SUB, 1, 0, zero, mkNum(0, 0, 32'h7000_0000), 0, 1, OP_SUB);
    addVec(B_OP_MUL, 1, 0, zero, mkNum(0, 0, 32'h7000_0000), 0, 1, OP_MUL);
    addVec(B_CLEAR, 1, 1, fortyTwo, zero, 0, 0, OP_NONE);
    addVec(B_OP_ADD, 1, 1, fortyTwo, fortyTwo, 0, 0, OP_NONE);
    addVec(B_OP_PERCENT, 1, 0, zero, fortyTwo, 0, 0, OP_NONE);
    addVec(B_MEM_PLUS, 1, 0, zero, fortyTwo, 0, 0, OP_NONE);
    addVec(B_NUM_4, 1, 0, zero, mkNum(0, 0, 32'h4000_0000), 1, 0, OP_NONE);
    addVec(B_OP_DIV, 1, 0, zero, mkNum(0, 0, 32'h4000_0000), 0, 1, OP_DIV);

    modelReset();
    #1 rstN = 1'b0;
    #11;
    checkOutput("reset", zero, 0, 0, OP_NONE);
    @(posedge clk);
    #1 rstN = 1'b1;
    checkOutput("reset_release", zero, 0, 0, OP_NONE);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].btn, vecs[i].ld, vecs[i].ldVal);
      checkOutput($sformatf("vec%0d", i), vecs[i].eNum, vecs[i].eEnt, vecs[i].eCom, vecs[i].eOp);
      for (int k = 1; k < vecs[i].hold + 2; k++) begin
        applyStimulus((k < vecs[i].hold) ? vecs[i].btn : B_NONE, 1'b0, zero);
        checkOutput($sformatf("vec%0d_hold%0d", i, k), vecs[i].eNum, vecs[i].eEnt, 1'b0, OP_NONE);
      end
    end

    // Reset in the middle of an entry while a key is held down.
    applyStimulus(B_NUM_3, 0, zero);
    applyStimulus(B_NONE, 0, zero);
    checkOutput("pre_reset_entry", mkNum(0, 0, 32'h3000_0000), 1, 0, OP_NONE);
    for (int k = 0; k < 5; k++) applyStimulus(B_NUM_5, 0, zero);
    checkOutput("held_5_pre_reset", mkNum(0, 1, 32'h3500_0000), 1, 0, OP_NONE);
    rstN = 1'b0;
    #1;
    checkOutput("async_reset", zero, 0, 0, OP_NONE);
    for (int k = 0; k < 3; k++) applyStimulus(B_NUM_5, 0, zero);
    checkOutput("in_reset", zero, 0, 0, OP_NONE);
    rstN = 1'b1;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(B_NUM_5, 0, zero);
      checkOutput($sformatf("post_reset_hold%0d", k), mkNum(0, 0, 32'h5000_0000), 1, 0, OP_NONE);
    end
    applyStimulus(B_NONE, 0, zero);
    for (int k = 0; k < 2; k++) applyStimulus(B_UNKNOWN, 0, zero);
    for (int k = 0; k < 2; k++) applyStimulus(B_NUM_5, 0, zero);
    checkOutput("unknown_then_5", mkNum(0, 0, 32'h5000_0000), 1, 0, OP_NONE);
    applyStimulus(B_NONE, 0, zero);
    applyStimulus(B_NUM_5, 0, zero);
    checkOutput("release_then_5", mkNum(0, 1, 32'h5500_0000), 1, 0, OP_NONE);
    applyStimulus(B_NONE, 0, zero);

    // Randomized key traffic against the model.
    for (int s = 0; s < 400; s++) begin
      int hold;
      int gap;
      rb   = randBtn();
      hold = $urandom_range(1, 3);
      gap  = $urandom_range(0, 2);
      for (int k = 0; k < hold + gap; k++) begin
        rl  = ($urandom_range(0, 99) < 4);
        rnd = {$urandom(), $urandom()};
        rv  = num_t'(rnd[37:0]);
        applyStimulus((k < hold) ? rb : B_NONE, rl, rv);
        checkOutput($sformatf("rand%0d_%0d", s, k), mNum, mEnt, mCommit, mOp);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
